// File: rtl/compare_unit.sv
// rtl/compare_unit.sv - registered compare unit; optional CMP_SIGNED_EN selects two's-complement ordering
module compare_unit #(
  parameter int DATA_W = 3,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] R1,
  input  logic [DATA_W-1:0] R2,
  output logic [DATA_W-1:0] RD,
  output logic              valid,
  output logic              illegal
);

  localparam logic [OP_W-1:0] OP_LT  = OP_W'(5'b01011);
  localparam logic [OP_W-1:0] OP_GT  = OP_W'(5'b01100);
  localparam logic [OP_W-1:0] OP_EQ  = OP_W'(5'b01101);
  localparam logic [OP_W-1:0] OP_GTE = OP_W'(5'b01110);
  localparam logic [OP_W-1:0] OP_LTE = OP_W'(5'b01111);
  localparam logic [OP_W-1:0] OP_NE  = OP_W'(5'b10000);

  logic lt;
  logic eq;
  logic outcome;
  logic is_cmp;

  // Every ordering relation is derived from one less-than and one equality
  // comparator, so only lt changes between the signed and unsigned builds.
  always_comb begin
`ifdef CMP_SIGNED_EN
    lt = $signed(R1) < $signed(R2);
`else
    lt = R1 < R2;
`endif
    eq      = (R1 == R2);
    is_cmp  = 1'b1;
    outcome = 1'b0;
    case (opcode)
      OP_LT:   outcome = lt;
      OP_GT:   outcome = !lt && !eq;
      OP_EQ:   outcome = eq;
      OP_GTE:  outcome = !lt;
      OP_LTE:  outcome = lt || eq;
      OP_NE:   outcome = !eq;
      default: is_cmp  = 1'b0;
    endcase
  end

  // Result register: boolean zero-extended into RD, flags describe the sampled opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RD      <= '0;
      valid   <= 1'b0;
      illegal <= 1'b0;
    end else begin
      RD      <= DATA_W'(outcome);
      valid   <= is_cmp;
      illegal <= !is_cmp;
    end
  end

endmodule

// File: tb/tb_compare_unit.sv
// tb/tb_compare_unit.sv - scoreboard bench for compare_unit
module tb_compare_unit;

  localparam int DATA_W = 3;
  localparam int OP_W   = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [OP_W-1:0]   opcode = '0;
  logic [DATA_W-1:0] R1 = '0;
  logic [DATA_W-1:0] R2 = '0;
  logic [DATA_W-1:0] RD;
  logic              valid;
  logic              illegal;

  int vectors = 0;
  int miscompares = 0;
  logic [DATA_W+1:0] sb_q[$];

  compare_unit #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .R1(R1), .R2(R2),
    .RD(RD), .valid(valid), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int to_int(input logic [DATA_W-1:0] v);
    int r;
    r = int'(v);
`ifdef CMP_SIGNED_EN
    if (v[DATA_W-1]) r = r - (1 << DATA_W);
`endif
    return r;
  endfunction

  // Expected {RD, valid, illegal} for one sampled input set.
  function automatic logic [DATA_W+1:0] model(input logic [4:0] op, input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    int ia, ib;
    logic res;
    ia = to_int(a);
    ib = to_int(b);
    case (op)
      5'b01011: res = (ia < ib);
      5'b01100: res = (ia > ib);
      5'b01101: res = (a == b);
      5'b01110: res = (ia >= ib);
      5'b01111: res = (ia <= ib);
      5'b10000: res = (a != b);
      default:  return {{DATA_W{1'b0}}, 2'b01};
    endcase
    return {{(DATA_W-1){1'b0}}, res, 2'b10};
  endfunction

  // Drive one vector after the falling edge, push its expectation, compare after the next rising edge.
  task automatic apply(input string tag, input logic [4:0] op, input int a, input int b);
    logic [DATA_W+1:0] exp;
    @(negedge clk);
    opcode = op;
    R1 = DATA_W'(a);
    R2 = DATA_W'(b);
    sb_q.push_back(model(op, DATA_W'(a), DATA_W'(b)));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      check_val(tag, {RD, valid, illegal}, exp);
    end
  endtask

  initial begin
    logic [4:0] ops[6];
    ops = '{5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b10000};

    // Reset held with clocks running
    opcode = 5'b01101; R1 = 3'd2; R2 = 3'd2;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_hold", {RD, valid, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("reset_release", {RD, valid, illegal}, {27'd0, 3'b001, 2'b10});

`ifndef CMP_SIGNED_EN
    apply("lt_3_5", 5'b01011, 3, 5);
    apply("lt_5_3", 5'b01011, 5, 3);
    apply("lt_3_3", 5'b01011, 3, 3);
    apply("gt_7_3", 5'b01100, 7, 3);
    apply("gt_3_7", 5'b01100, 3, 7);
    apply("gt_7_7", 5'b01100, 7, 7);
    apply("lt_0_7", 5'b01011, 0, 7);
    apply("gte_0_7", 5'b01110, 0, 7);
`else
    apply("s_lt_7_3", 5'b01011, 7, 3);
    apply("s_gt_7_3", 5'b01100, 7, 3);
    apply("s_lt_3_4", 5'b01011, 3, 4);
`endif
    apply("eq_2_2", 5'b01101, 2, 2);
    apply("eq_1_6", 5'b01101, 1, 6);
    apply("ne_2_6", 5'b10000, 2, 6);
    apply("ne_2_2", 5'b10000, 2, 2);
    apply("gte_6_1", 5'b01110, 6, 1);
    apply("gte_4_4", 5'b01110, 4, 4);
    apply("gte_2_4", 5'b01110, 2, 4);
    apply("lte_2_6", 5'b01111, 2, 6);
    apply("lte_7_7", 5'b01111, 7, 7);
    apply("lte_7_3", 5'b01111, 7, 3);

    // Illegal opcodes interleaved with legal ones, no bubbles
    apply("ill_00000", 5'b00000, 5, 5);
    apply("alt_eq", 5'b01101, 5, 5);
    apply("ill_01010", 5'b01010, 5, 5);
    apply("alt_ne", 5'b10000, 5, 4);
    apply("ill_10001", 5'b10001, 5, 5);
    apply("alt_lte", 5'b01111, 5, 5);
    apply("ill_11111", 5'b11111, 5, 5);

    // Asynchronous reset between edges while RD = 1
    apply("pre_rst_eq", 5'b01101, 3, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst", {RD, valid, illegal}, 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_rst_eq", 5'b01101, 4, 4);

    // Random mix of legal and illegal opcodes
    for (int i = 0; i < 40; i++) begin
      logic [4:0] op;
      if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 31));
      else op = ops[$urandom_range(0, 5)];
      apply("rand", op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
